// File: rtl/register_access_if.sv
// Decode-to-execute bus of the register-access stage: the decoded instruction
// offered by decode, and the operand bundle handed on to execute.
interface register_access_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EXEC_OP_W  = 5,
  parameter int CTRL_W     = 8
);
  // decode side
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] register_number_a;
  logic [REG_ADDR_W-1:0] register_number_b;
  logic                  pc_for_a;
  logic                  immediate_value_for_b;
  logic [XLEN-1:0]       pc;
  logic [XLEN-1:0]       immediate_value;
  logic [EXEC_OP_W-1:0]  execute_instruction_input;
  logic [CTRL_W-1:0]     ctrl_input;
  logic [REG_ADDR_W-1:0] destination_register_number_input;
  logic                  jalr_input;

  // execute side
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       data_a;
  logic [XLEN-1:0]       data_b;
  logic [XLEN-1:0]       rs2_value;
  logic [EXEC_OP_W-1:0]  execute_instruction_output;
  logic [CTRL_W-1:0]     ctrl_output;
  logic [XLEN-1:0]       immediate_value_output;
  logic [XLEN-1:0]       pc_output;
  logic [REG_ADDR_W-1:0] destination_register_number_output;
  logic                  jalr_output;
  logic [XLEN-1:0]       new_pc;

  // environment: drives decode inputs and execute back-pressure
  modport master (
    output in_valid, register_number_a, register_number_b, pc_for_a,
           immediate_value_for_b, pc, immediate_value, execute_instruction_input,
           ctrl_input, destination_register_number_input, jalr_input, out_ready,
    input  in_ready, out_valid, data_a, data_b, rs2_value,
           execute_instruction_output, ctrl_output, immediate_value_output,
           pc_output, destination_register_number_output, jalr_output, new_pc
  );

  // the stage itself
  modport slave (
    input  in_valid, register_number_a, register_number_b, pc_for_a,
           immediate_value_for_b, pc, immediate_value, execute_instruction_input,
           ctrl_input, destination_register_number_input, jalr_input, out_ready,
    output in_ready, out_valid, data_a, data_b, rs2_value,
           execute_instruction_output, ctrl_output, immediate_value_output,
           pc_output, destination_register_number_output, jalr_output, new_pc
  );
endinterface

// File: rtl/register_access_stage.sv
// Register-access pipeline stage: owns the architectural register file, reads
// two operands with write-back bypass, holds one instruction for execute under
// back-pressure (refreshing its operands from write-back while stalled), and
// forms the JALR target from the held rs1 value.
module register_access_stage #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EXEC_OP_W  = 5,
  parameter int CTRL_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  write_back_enable,
  input  logic [REG_ADDR_W-1:0] destination_register_number,
  input  logic [XLEN-1:0]       write_back_data,
  register_access_if.slave      bus
);

  logic [XLEN-1:0]       regs [REG_COUNT];

  logic                  out_valid_q;
  logic [XLEN-1:0]       data_a_q;
  logic [XLEN-1:0]       data_b_q;
  logic [XLEN-1:0]       rs1_value_q;
  logic [XLEN-1:0]       rs2_value_q;
  logic [REG_ADDR_W-1:0] rs1_num_q;
  logic [REG_ADDR_W-1:0] rs2_num_q;
  logic                  pc_sel_q;
  logic                  imm_sel_q;
  logic [EXEC_OP_W-1:0]  exec_op_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [XLEN-1:0]       imm_q;
  logic [XLEN-1:0]       pc_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  jalr_q;

  logic                  wb_hit;
  logic                  in_ready;
  logic                  accept;
  logic                  leave;
  logic                  stalled;
  logic [XLEN-1:0]       rs1_val;
  logic [XLEN-1:0]       rs2_val;
  logic [XLEN-1:0]       jalr_sum;

  // A write-back that actually lands in the file (nonzero, in range).
  assign wb_hit   = write_back_enable && (destination_register_number != '0) &&
                    (int'(destination_register_number) < REG_COUNT);
  // Ready held high while reset is asserted so decode never sees a dead stage.
  assign in_ready = reset || !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign leave    = out_valid_q && bus.out_ready;
  assign stalled  = out_valid_q && !bus.out_ready;

  // Operand read with write-first bypass; x0 and unmapped numbers read zero.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (bus.register_number_a != '0 && int'(bus.register_number_a) < REG_COUNT) begin
      if (wb_hit && destination_register_number == bus.register_number_a)
        rs1_val = write_back_data;
      else
        rs1_val = regs[bus.register_number_a];
    end
    if (bus.register_number_b != '0 && int'(bus.register_number_b) < REG_COUNT) begin
      if (wb_hit && destination_register_number == bus.register_number_b)
        rs2_val = write_back_data;
      else
        rs2_val = regs[bus.register_number_b];
    end
  end

  // Architectural register file; flush does not suppress write-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[destination_register_number] <= write_back_data;
    end
  end

  // Held instruction: reset > flush > accept > operand refresh while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      rs1_value_q <= '0;
      rs2_value_q <= '0;
      rs1_num_q   <= '0;
      rs2_num_q   <= '0;
      pc_sel_q    <= 1'b0;
      imm_sel_q   <= 1'b0;
      exec_op_q   <= '0;
      ctrl_q      <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      jalr_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      data_a_q    <= bus.pc_for_a ? bus.pc : rs1_val;
      data_b_q    <= bus.immediate_value_for_b ? bus.immediate_value : rs2_val;
      rs1_value_q <= rs1_val;
      rs2_value_q <= rs2_val;
      rs1_num_q   <= bus.register_number_a;
      rs2_num_q   <= bus.register_number_b;
      pc_sel_q    <= bus.pc_for_a;
      imm_sel_q   <= bus.immediate_value_for_b;
      exec_op_q   <= bus.execute_instruction_input;
      ctrl_q      <= bus.ctrl_input;
      imm_q       <= bus.immediate_value;
      pc_q        <= bus.pc;
      rd_q        <= bus.destination_register_number_input;
      jalr_q      <= bus.jalr_input;
    end else begin
      if (leave) out_valid_q <= 1'b0;
      if (stalled && wb_hit) begin
        if (destination_register_number == rs1_num_q) begin
          rs1_value_q <= write_back_data;
          if (!pc_sel_q) data_a_q <= write_back_data;
        end
        if (destination_register_number == rs2_num_q) begin
          rs2_value_q <= write_back_data;
          if (!imm_sel_q) data_b_q <= write_back_data;
        end
      end
    end
  end

  // JALR target follows the held rs1 value so stall refreshes are reflected.
  assign jalr_sum = rs1_value_q + imm_q;

  assign bus.in_ready                           = in_ready;
  assign bus.out_valid                          = out_valid_q;
  assign bus.data_a                             = data_a_q;
  assign bus.data_b                             = data_b_q;
  assign bus.rs2_value                          = rs2_value_q;
  assign bus.execute_instruction_output         = exec_op_q;
  assign bus.ctrl_output                        = ctrl_q;
  assign bus.immediate_value_output             = imm_q;
  assign bus.pc_output                          = pc_q;
  assign bus.destination_register_number_output = rd_q;
  assign bus.jalr_output                        = out_valid_q && jalr_q;
  assign bus.new_pc                             = {jalr_sum[XLEN-1:1], 1'b0};

endmodule

// File: tb/tb_register_access_stage.sv
// Directed bench for register_access_stage: hand-computed expectations for
// reset, bypass, stall refresh, JALR target, throughput, flush and mid-stream reset.
module tb_register_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        write_back_enable;
  logic [4:0]  destination_register_number;
  logic [31:0] write_back_data;

  int checks = 0;
  int errors = 0;

  register_access_if bus ();

  register_access_stage dut (
    .clk                         (clk),
    .reset                       (reset),
    .flush                       (flush),
    .write_back_enable           (write_back_enable),
    .destination_register_number (destination_register_number),
    .write_back_data             (write_back_data),
    .bus                         (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] val);
    write_back_enable           = en;
    destination_register_number = rd;
    write_back_data             = val;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic psel,
                       input logic isel, input logic [31:0] pcv, input logic [31:0] imm,
                       input logic jalr);
    bus.in_valid              = 1'b1;
    bus.register_number_a     = rs1;
    bus.register_number_b     = rs2;
    bus.pc_for_a              = psel;
    bus.immediate_value_for_b = isel;
    bus.pc                    = pcv;
    bus.immediate_value       = imm;
    bus.jalr_input            = jalr;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    bus.in_valid = 1'b0;
    bus.register_number_a = '0;
    bus.register_number_b = '0;
    bus.pc_for_a = 1'b0;
    bus.immediate_value_for_b = 1'b0;
    bus.pc = '0;
    bus.immediate_value = '0;
    bus.execute_instruction_input = '0;
    bus.ctrl_input = '0;
    bus.destination_register_number_input = '0;
    bus.jalr_input = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #1;
    chk("rst_in_ready_during", bus.in_ready, 1);
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_a", bus.data_a, 0);
    chk("rst_new_pc", bus.new_pc, 0);
    chk("rst_jalr_out", bus.jalr_output, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_after", bus.in_ready, 1);

    // preload x1, x2, x5
    wb(1'b1, 5'd1, 32'h1001); step();
    wb(1'b1, 5'd2, 32'h22);   step();
    wb(1'b1, 5'd5, 32'h55);   step();

    // bypass: x3 written in the accept cycle
    bus.out_ready = 1'b1;
    issue(5'd3, 5'd2, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
    wb(1'b1, 5'd3, 32'h1234);
    step();
    chk("byp_out_valid", bus.out_valid, 1);
    chk("byp_data_a", bus.data_a, 32'h1234);
    chk("byp_data_b", bus.data_b, 32'h22);
    chk("byp_rs2_value", bus.rs2_value, 32'h22);
    // rs1 = x0 with a write to x0
    issue(5'd0, 5'd2, 1'b0, 1'b0, 32'h104, 32'h0, 1'b0);
    wb(1'b1, 5'd0, 32'hDEAD);
    step();
    chk("byp_x0_data_a", bus.data_a, 0);

    // JALR: x1 = 0x1001, imm 6, data_a selects PC
    issue(5'd1, 5'd2, 1'b1, 1'b0, 32'h400, 32'h6, 1'b1);
    bus.execute_instruction_input = 5'd5;
    bus.ctrl_input = 8'hA5;
    bus.destination_register_number_input = 5'd9;
    wb(1'b0, 5'd0, 32'h0);
    step();
    chk("jalr_new_pc", bus.new_pc, 32'h1006);
    chk("jalr_output", bus.jalr_output, 1);
    chk("jalr_data_a_pc", bus.data_a, 32'h400);
    chk("jalr_pc_output", bus.pc_output, 32'h400);
    chk("jalr_exec_op", bus.execute_instruction_output, 5'd5);
    chk("jalr_ctrl", bus.ctrl_output, 8'hA5);
    chk("jalr_rd", bus.destination_register_number_output, 5'd9);
    // stall, refresh x1
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    wb(1'b1, 5'd1, 32'h2000);
    step();
    chk("jalr_refresh_new_pc", bus.new_pc, 32'h2006);
    chk("jalr_refresh_data_a_kept", bus.data_a, 32'h400);
    chk("jalr_stall_in_ready", bus.in_ready, 0);

    // stall refresh: rs2 = 7 with immediate operand b
    bus.out_ready = 1'b1;
    issue(5'd3, 5'd7, 1'b0, 1'b1, 32'h200, 32'h10, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    step();
    chk("stl_data_b", bus.data_b, 32'h10);
    chk("stl_rs2_value_init", bus.rs2_value, 0);
    chk("stl_data_a", bus.data_a, 32'h1234);
    chk("stl_jalr_out", bus.jalr_output, 0);
    bus.out_ready = 1'b0;
    issue(5'd3, 5'd7, 1'b0, 1'b1, 32'h204, 32'h99, 1'b0);
    wb(1'b1, 5'd7, 32'hAA);
    step();
    chk("stl_data_b_kept", bus.data_b, 32'h10);
    chk("stl_rs2_refresh", bus.rs2_value, 32'hAA);
    chk("stl_in_ready", bus.in_ready, 0);
    chk("stl_out_valid", bus.out_valid, 1);
    chk("stl_imm_held", bus.immediate_value_output, 32'h10);
    wb(1'b1, 5'd3, 32'h77);
    step();
    chk("stl_data_a_refresh", bus.data_a, 32'h77);
    chk("stl_new_pc_refresh", bus.new_pc, 32'h86);

    // throughput: four back-to-back accepts
    bus.out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      issue(5'd0, 5'd0, 1'b0, 1'b1, 32'h300, k, 1'b0);
      step();
      chk("thr_out_valid", bus.out_valid, 1);
      chk("thr_order", bus.data_b, k);
    end
    bus.in_valid = 1'b0;
    step();
    chk("thr_drain", bus.out_valid, 0);

    // flush with incoming instruction; write-back still lands
    issue(5'd0, 5'd0, 1'b0, 1'b1, 32'h500, 32'h55, 1'b0);
    flush = 1'b1;
    wb(1'b1, 5'd4, 32'h44);
    #1;
    chk("fl_in_ready_ungated", bus.in_ready, 1);
    step();
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_dropped", bus.immediate_value_output, 32'h4);
    flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    issue(5'd4, 5'd0, 1'b0, 1'b1, 32'h504, 32'h66, 1'b0);
    step();
    chk("fl_wb_kept", bus.data_a, 32'h44);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b1;
    step();
    chk("fl_held_killed", bus.out_valid, 0);
    flush = 1'b0;

    // reset mid-stream
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      issue(5'd5, 5'd0, 1'b0, 1'b0, 32'h600 + 4 * k, 32'h0, 1'b0);
      step();
    end
    chk("mid_data_a", bus.data_a, 32'h55);
    chk("mid_pc_output", bus.pc_output, 32'h608);
    reset = 1'b1;
    step();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_data_a", bus.data_a, 0);
    chk("mid_rst_pc_output", bus.pc_output, 0);
    reset = 1'b0;
    issue(5'd5, 5'd0, 1'b0, 1'b0, 32'h700, 32'h0, 1'b0);
    step();
    chk("mid_x5_cleared", bus.data_a, 0);
    chk("mid_valid_again", bus.out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_access_stage.md
Name: register_access_stage

Overview:
- Parametrised register-access pipeline stage for the RISC-V core. Sits between decode and execute.
- Holds the architectural register file, reads two operands and selects PC/immediate operands.
- Computes the JALR target and registers decode sideband toward execute.
- Compared with the fixed-width version, it adds:
  - a valid/ready handshake with back-pressure;
  - flush;
  - write-back bypass;
  - operand refresh while a stalled instruction is held.

Parameters:
XLEN, 32, data/PC width
REG_COUNT, 32, architectural registers; register 0 reads zero
REG_ADDR_W, 5, register number width, must satisfy 2**REG_ADDR_W >= REG_COUNT
EXEC_OP_W, 5, execute instruction code width
CTRL_W, 8, opaque sideband bundle (condition_branch, taken, read/write status, load_unsigned, write_back_type)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept this cycle
register_number_a  in  REG_ADDR_W  rs1
register_number_b  in  REG_ADDR_W  rs2
pc_for_a  in  1  data_a = pc instead of rs1
immediate_value_for_b  in  1  data_b = immediate instead of rs2
pc  in  XLEN  instruction PC
immediate_value  in  XLEN  decoded immediate
execute_instruction_input  in  EXEC_OP_W  ALU op
ctrl_input  in  CTRL_W  passthrough sideband
destination_register_number_input  in  REG_ADDR_W  rd
jalr_input  in  1  instruction is JALR
out_valid  out  1  output bundle valid
out_ready  in  1  execute accepts bundle
data_a, data_b, rs2_value  out  XLEN  operands
execute_instruction_output  out  EXEC_OP_W  registered op
ctrl_output  out  CTRL_W  registered sideband
immediate_value_output, pc_output  out  XLEN  registered
destination_register_number_output  out  REG_ADDR_W  registered rd
jalr_output  out  1  out_valid & held jalr
new_pc  out  XLEN  (rs1 value + immediate) with bit 0 cleared
flush  in  1  kill held and incoming instruction
write_back_enable  in  1  write-back strobe
destination_register_number  in  REG_ADDR_W  write-back rd
write_back_data  in  XLEN  write-back value

Behaviour:
- Reset:
  - All registers, out_valid and every output are 0.
  - in_ready = 1 during and after reset.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready.
  - Latency is 1 cycle: the accepted bundle appears with out_valid=1 on the next edge.
  - A bundle leaves when out_valid & out_ready; with no new accept, out_valid drops to 0.
  - Accept and leave in the same cycle gives back-to-back issue at full throughput.
- Register file:
  - Write on posedge when write_back_enable and destination_register_number != 0.
  - Writes to register 0, or to numbers >= REG_COUNT, are ignored.
  - Reads of register 0 or out-of-range numbers return 0.
- Bypass on accept:
  - If the write is enabled and its rd matches a nonzero rs, the captured value is write_back_data (write-first).
- Operand capture:
  - data_a = pc_for_a ? pc : rs1val.
  - data_b = immediate_value_for_b ? immediate_value : rs2val.
  - rs2_value = rs2val.
  - The stage also holds rs1val, rs1/rs2 numbers and both select bits internally.
- Refresh while held (out_valid & !out_ready, no accept), for a write to nonzero rd:
  - Write rd == held rs1: update held rs1val; update data_a only if !pc_for_a.
  - Write rd == held rs2: update rs2_value; update data_b only if !immediate_value_for_b.
- JALR target:
  - new_pc = (held rs1val + immediate_value_output) mod 2^XLEN, bit 0 forced 0.
  - Combinational from registered state, so it tracks refreshes.
  - jalr_output = out_valid & held jalr.
- Flush:
  - Next edge out_valid = 0 and any same-cycle accept is discarded.
  - in_ready is not gated.
  - Register-file writes still occur.
- Priority: reset > flush > accept > refresh.
- Unchanged fields: outputs other than out_valid hold their values when not accepting.

Test Plan:
- Reset mid-stream: issue 3 instructions, assert reset → out_valid=0 and all outputs 0 next edge; read of x5 returns 0.
- Bypass: write x3=0x1234 in the cycle rs1=3 is accepted, pc_for_a=0 → data_a=0x1234 next cycle; rs1=0 with a write to x0 → data_a=0.
- Stall refresh: hold out_ready=0 with rs2=7, immediate_value_for_b=1, imm=0x10; write x7=0xAA → data_b stays 0x10, rs2_value=0xAA, in_ready=0.
- JALR: x1=0x1001, imm=0x6, jalr=1 → new_pc=0x1006, jalr_output=1; a later write x1=0x2000 during stall → new_pc=0x2006.
- Throughput/flush: out_ready=1 and 4 back-to-back in_valid → 4 consecutive out_valid beats in order; flush with in_valid=1 → out_valid=0 next cycle, instruction dropped.
